// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths.
// UART_TX_PARITY_EN widens the transmitter state type to include an even-parity bit state.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_BITS  = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with registered full/empty flags and an occupancy count.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + (AW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - (AW + 1)'(1);
    end
  end

  // Flags come from the next count so they are plain flops: a pop never raises full's complement early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised LSB first, idle-high, 8N1.
// Define UART_TX_PARITY_EN for 8E1 frames with an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_rxd_out
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  if (CLKS_PER_BIT < 2) begin : g_baud_check
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t                 state;
  logic [CNT_W-1:0]          baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [FIFO_CW-1:0]        fifo_count;
  logic                      baud_wrap;
  logic                      line_next;
`ifdef UART_TX_PARITY_EN
  logic                      parity;
`endif

  uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign baud_wrap = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign fifo_pop  = !fifo_empty && ((state == TX_IDLE) || (state == TX_STOP && baud_wrap));

  always_comb begin
    line_next = UART_IDLE_LEVEL;
    case (state)
      TX_START:  line_next = ~UART_IDLE_LEVEL;
      TX_DATA:   line_next = shift[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: line_next = parity;
`endif
      default:   line_next = UART_IDLE_LEVEL;
    endcase
  end

  // The line is a registered copy of the current state's level, so it trails the state by one cycle
  // and every bit keeps its full CLKS_PER_BIT width; busy is registered on the same timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= TX_IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
`ifdef UART_TX_PARITY_EN
      parity       <= 1'b0;
`endif
      uart_rxd_out <= UART_IDLE_LEVEL;
      tx_busy      <= 1'b0;
    end else begin
      uart_rxd_out <= line_next;
      tx_busy      <= (fifo_count != '0) || (state != TX_IDLE);
      baud_cnt     <= (state == TX_IDLE || baud_wrap) ? '0 : baud_cnt + CNT_W'(1);
      if (fifo_pop) begin
        shift <= fifo_head;
`ifdef UART_TX_PARITY_EN
        parity <= ^fifo_head;
`endif
      end
      case (state)
        TX_IDLE: begin
          if (fifo_pop) begin
            state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_wrap) begin
            state   <= TX_DATA;
            bit_idx <= '0;
          end
        end
        TX_DATA: begin
          if (baud_wrap) begin
            shift <= shift >> 1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= TX_PARITY;
`else
              state <= TX_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (baud_wrap) begin
            state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (baud_wrap) begin
            state <= fifo_pop ? TX_START : TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, burst/reset sequences and randomized producer traffic.
module tb_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam int FRAME_CYC   = NBITS * CPB;
  localparam int WAIT_BUDGET = 20 * FRAME_CYC;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_busy;
  logic       uart_rxd_out;

  int         errors      = 0;
  int         checks      = 0;
  int         cyc         = 0;
  int         frames_done = 0;
  bit         mon_en      = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];
  logic [10:0] last_frame;
  logic [7:0] mon_d;
  bit         mon_have;
  int         mon_bad;

  vec_t       vecs [12];
  logic [7:0] burst [6];

  uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .uart_rxd_out (uart_rxd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Level the line should carry during bit slot idx of a frame carrying d.
  function automatic logic expected_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic [10:0] expected_frame(input logic [7:0] d, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b0, 1'b1, par, d, 1'b0};
`else
    return {2'b00, 1'b1, d, 1'b0} | {10'd0, par & 1'b0};
`endif
  endfunction

  // Must be called at a negedge; returns the posedge number at which the byte was taken.
  task automatic applyStimulus(input logic [7:0] d, output int acc_cyc);
    int waited;
    waited   = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < WAIT_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      checkOutput("accept_timeout", {31'd0, tx_ready}, 32'd1);
      tx_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    acc_cyc = cyc + 1;
    exp_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic waitFrames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < WAIT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_wait", {31'd0, frames_done >= target}, 32'd1);
  endtask

  task automatic waitIdle(output int idle_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b0 && n < WAIT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", {31'd0, tx_busy === 1'b0}, 32'd1);
    idle_cyc = cyc;
  endtask

  // Line monitor: every cycle of a frame is compared with the level the frame rules predict.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && uart_rxd_out === 1'b0) begin
        mon_have = (exp_q.size() > 0);
        mon_d    = mon_have ? exp_q.pop_front() : 8'h00;
        starts.push_back(cyc);
        mon_bad    = 0;
        last_frame = '0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n || !mon_en) break;
          if (uart_rxd_out !== expected_bit(mon_d, k / CPB)) mon_bad++;
          if (k % CPB == CPB / 2) last_frame[k/CPB] = uart_rxd_out;
        end
        checkOutput("frame_expected", {31'd0, mon_have}, 32'd1);
        checkOutput("frame_wave", mon_bad, 0);
        frames_done++;
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc_cyc [6];
    int base;
    int n0;
    int idle_cyc;
    int nacc;
    int bad_line;
    int bad_ready;
    int bad_busy;
    int gap_bad;
    int n;

    vecs[0]  = '{8'hA5, 1'b0};
    vecs[1]  = '{8'h07, 1'b1};
    vecs[2]  = '{8'h03, 1'b0};
    vecs[3]  = '{8'hFF, 1'b0};
    vecs[4]  = '{8'h3C, 1'b0};
    vecs[5]  = '{8'h0F, 1'b0};
    vecs[6]  = '{8'h12, 1'b0};
    vecs[7]  = '{8'h01, 1'b1};
    vecs[8]  = '{8'h80, 1'b1};
    vecs[9]  = '{8'hB6, 1'b1};
    vecs[10] = '{8'hE3, 1'b1};
    vecs[11] = '{8'h5A, 1'b0};
    burst[0] = 8'h00;
    burst[1] = 8'hFF;
    burst[2] = 8'h55;
    burst[3] = 8'h3C;
    burst[4] = 8'h81;
    burst[5] = 8'h6E;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_line", {31'd0, uart_rxd_out}, 32'd1);
    checkOutput("reset_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1'b1;

    bad_line  = 0;
    bad_ready = 0;
    bad_busy  = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_rxd_out !== 1'b1) bad_line++;
      if (tx_ready !== 1'b1) bad_ready++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    checkOutput("idle_line", bad_line, 0);
    checkOutput("idle_ready", bad_ready, 0);
    checkOutput("idle_busy", bad_busy, 0);
    mon_en = 1'b1;

    $display("[TB] vector table: %0d single-byte frames", 12);
    for (int i = 0; i < 12; i++) begin
      base = frames_done;
      applyStimulus(vecs[i].data, acc);
      waitFrames(base + 1);
      checkOutput($sformatf("vec%0d_frame", i), {21'd0, last_frame},
                  {21'd0, expected_frame(vecs[i].data, vecs[i].par)});
      checkOutput($sformatf("vec%0d_latency", i), starts[$] - acc, 2);
    end

    $display("[TB] back-to-back burst");
    repeat (5) @(negedge clk);
    base = frames_done;
    n0   = starts.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(burst[i], acc_cyc[i]);
      if (i == 4) checkOutput("burst_full_after_5", {31'd0, tx_ready}, 32'd0);
    end
    checkOutput("burst_first5_consecutive", acc_cyc[4] - acc_cyc[0], 4);
    checkOutput("burst_6th_accept", acc_cyc[5], starts[n0] + FRAME_CYC);
    waitIdle(idle_cyc);
    checkOutput("burst_frames", frames_done - base, 6);
    gap_bad = 0;
    for (int i = n0 + 1; i < starts.size(); i++) begin
      if (starts[i] - starts[i-1] != FRAME_CYC) gap_bad++;
    end
    checkOutput("burst_no_gap", gap_bad, 0);
    checkOutput("burst_busy_fall", idle_cyc - starts[$], FRAME_CYC);

    $display("[TB] reset in mid-frame");
    mon_en = 1'b0;
    applyStimulus(8'h0F, acc);
    applyStimulus(8'h77, acc);
    n = 0;
    while (uart_rxd_out !== 1'b0 && n < WAIT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_frame_started", {31'd0, uart_rxd_out}, 32'd0);
    repeat (55) @(negedge clk);
    checkOutput("rst_pre_line", {31'd0, uart_rxd_out}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_line_immediate", {31'd0, uart_rxd_out}, 32'd1);
    checkOutput("rst_busy_immediate", {31'd0, tx_busy}, 32'd0);
    checkOutput("rst_ready_immediate", {31'd0, tx_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    base   = frames_done;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("post_rst_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("post_rst_no_stale_frame", frames_done - base, 0);
    applyStimulus(8'h12, acc);
    waitFrames(base + 1);
    checkOutput("post_rst_frame", {21'd0, last_frame}, {21'd0, expected_frame(8'h12, 1'b0)});
    waitIdle(idle_cyc);

    $display("[TB] randomized producer traffic");
    base = frames_done;
    nacc = 0;
    for (int i = 0; i < 700; i++) begin
      tx_valid = (i < 60) ? 1'b1 : ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      if (tx_valid && tx_ready === 1'b1) begin
        exp_q.push_back(tx_data);
        nacc++;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    waitIdle(idle_cyc);
    checkOutput("random_frames", frames_done - base, nacc);
    checkOutput("random_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
